// File: rtl/imuldiv_mul_arbiter_pkg.sv
// Shared definitions for the two-port multiplier arbiter.
//   PORT_ID_BITS : width of a requester ID carried in the tag FIFO
//   port_id_t    : requester ID type
//   ARB_PORT0/1  : requester ID constants
//   other_port() : returns the requester that is not the argument
package imuldiv_mul_arbiter_pkg;

    localparam int PORT_ID_BITS = 1;

    typedef logic [PORT_ID_BITS-1:0] port_id_t;

    localparam port_id_t ARB_PORT0 = 1'b0;
    localparam port_id_t ARB_PORT1 = 1'b1;

    function automatic port_id_t other_port(input port_id_t p);
        return (p == ARB_PORT0) ? ARB_PORT1 : ARB_PORT0;
    endfunction

endpackage

// File: rtl/imuldiv_mul_arbiter_tag_queue.sv
// In-order tag FIFO: remembers which requester issued each multiply that is
// still in flight so the result can be routed back to it.
//   clk, reset        : clock, synchronous active-high reset (empties FIFO)
//   enq_val / enq_rdy : push handshake, enq_rdy low when full
//   enq_msg           : tag to push
//   deq_val / deq_rdy : pop handshake, deq_val high when not empty
//   deq_msg           : tag at the head
// A full FIFO refuses a push even if a pop happens in the same cycle.
module imuldiv_mul_arbiter_tag_queue #(
    parameter int p_tag_bits  = 1,
    parameter int p_tag_depth = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enq_val,
    output logic                  enq_rdy,
    input  logic [p_tag_bits-1:0] enq_msg,
    output logic                  deq_val,
    input  logic                  deq_rdy,
    output logic [p_tag_bits-1:0] deq_msg
);

    localparam int PTR_W = $clog2(p_tag_depth);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(p_tag_depth);

    logic [p_tag_bits-1:0] mem [p_tag_depth];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  do_enq;
    logic                  do_deq;

    assign enq_rdy = (count != CNT_DEPTH);
    assign deq_val = (count != '0);
    assign deq_msg = mem[rd_ptr];

    assign do_enq = enq_val && enq_rdy;
    assign do_deq = deq_val && deq_rdy;

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[wr_ptr] <= enq_msg;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imuldiv_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between two
// requesters. Requests are granted combinationally, the issuing port is
// recorded in an in-order tag FIFO, and each result is steered back to the
// port at the FIFO head. No cycles are added on either path.
//   clk, reset                      : clock, synchronous active-high reset
//   req{0,1}_msg_a/_msg_b           : requester operands (32b each)
//   req{0,1}_val / req{0,1}_rdy     : requester request handshake
//   resp{0,1}_msg_result            : result to requester (64b)
//   resp{0,1}_val / resp{0,1}_rdy   : requester response handshake
//   mulreq_msg_a/_msg_b             : operands to the multiplier
//   mulreq_val / mulreq_rdy         : multiplier request handshake
//   mulresp_msg_result              : result from the multiplier
//   mulresp_val / mulresp_rdy       : multiplier response handshake
module imuldiv_mul_arbiter
    import imuldiv_mul_arbiter_pkg::*;
#(
    parameter int p_tag_depth = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] req0_msg_a,
    input  logic [31:0] req0_msg_b,
    input  logic        req0_val,
    output logic        req0_rdy,
    output logic [63:0] resp0_msg_result,
    output logic        resp0_val,
    input  logic        resp0_rdy,

    input  logic [31:0] req1_msg_a,
    input  logic [31:0] req1_msg_b,
    input  logic        req1_val,
    output logic        req1_rdy,
    output logic [63:0] resp1_msg_result,
    output logic        resp1_val,
    input  logic        resp1_rdy,

    output logic [31:0] mulreq_msg_a,
    output logic [31:0] mulreq_msg_b,
    output logic        mulreq_val,
    input  logic        mulreq_rdy,

    input  logic [63:0] mulresp_msg_result,
    input  logic        mulresp_val,
    output logic        mulresp_rdy
);

    port_id_t prio;
    port_id_t grant;
    port_id_t head_tag;
    logic     q_enq_rdy;
    logic     q_deq_val;
    logic     can_issue;
    logic     can_return;
    logic     issue;
    logic     ret;

    // While reset is high the FIFO is presented as empty so no stale tag
    // can route a response and every issue slot looks available.
    assign can_issue  = q_enq_rdy || reset;
    assign can_return = q_deq_val && !reset;

    always_comb begin
        grant = ARB_PORT0;
        if (req0_val && req1_val) begin
            grant = prio;
        end else if (req1_val) begin
            grant = ARB_PORT1;
        end
    end

    assign mulreq_val = (req0_val || req1_val) && can_issue;
    assign issue      = mulreq_val && mulreq_rdy;

    // Idle cycles fall back to port 0's operands.
    always_comb begin
        mulreq_msg_a = req0_msg_a;
        mulreq_msg_b = req0_msg_b;
        if (grant == ARB_PORT1) begin
            mulreq_msg_a = req1_msg_a;
            mulreq_msg_b = req1_msg_b;
        end
    end

    // A port loses its rdy only when the other port holds the grant with a
    // valid request; with no requests pending both see the issue slot.
    assign req0_rdy = mulreq_rdy && can_issue && !(req1_val && (grant == ARB_PORT1));
    assign req1_rdy = mulreq_rdy && can_issue && !(req0_val && (grant == ARB_PORT0));

    assign resp0_val   = mulresp_val && can_return && (head_tag == ARB_PORT0);
    assign resp1_val   = mulresp_val && can_return && (head_tag == ARB_PORT1);
    assign mulresp_rdy = can_return && ((head_tag == ARB_PORT0) ? resp0_rdy : resp1_rdy);
    assign ret         = mulresp_val && mulresp_rdy;

    assign resp0_msg_result = mulresp_msg_result;
    assign resp1_msg_result = mulresp_msg_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= ARB_PORT0;
        end else if (issue) begin
            prio <= other_port(grant);
        end
    end

    imuldiv_mul_arbiter_tag_queue #(
        .p_tag_bits  (PORT_ID_BITS),
        .p_tag_depth (p_tag_depth)
    ) u_tag_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (issue),
        .enq_rdy (q_enq_rdy),
        .enq_msg (grant),
        .deq_val (q_deq_val),
        .deq_rdy (ret),
        .deq_msg (head_tag)
    );

endmodule

// File: tb/tb_imuldiv_mul_arbiter.sv
// Bench for imuldiv_mul_arbiter: the bench plays both requesters, both
// response sinks and an in-order multiplier. A behavioural model (list of
// in-flight port IDs plus a priority bit) predicts every arbiter output each
// cycle; per-port golden queues check that every result reaches its own port
// in order; literal expectations pin the scripted scenarios.
module tb_imuldiv_mul_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] req0_msg_a = '0, req0_msg_b = '0, req1_msg_a = '0, req1_msg_b = '0;
    logic        req0_val = 1'b0, req1_val = 1'b0;
    logic        req0_rdy, req1_rdy;
    logic [63:0] resp0_msg_result, resp1_msg_result;
    logic        resp0_val, resp1_val;
    logic        resp0_rdy = 1'b1, resp1_rdy = 1'b1;
    logic [31:0] mulreq_msg_a, mulreq_msg_b;
    logic        mulreq_val;
    logic        mulreq_rdy = 1'b1;
    logic [63:0] mulresp_msg_result = '0;
    logic        mulresp_val = 1'b0;
    logic        mulresp_rdy;

    always #5 clk = ~clk;

    imuldiv_mul_arbiter #(.p_tag_depth(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .req0_msg_a         (req0_msg_a),
        .req0_msg_b         (req0_msg_b),
        .req0_val           (req0_val),
        .req0_rdy           (req0_rdy),
        .resp0_msg_result   (resp0_msg_result),
        .resp0_val          (resp0_val),
        .resp0_rdy          (resp0_rdy),
        .req1_msg_a         (req1_msg_a),
        .req1_msg_b         (req1_msg_b),
        .req1_val           (req1_val),
        .req1_rdy           (req1_rdy),
        .resp1_msg_result   (resp1_msg_result),
        .resp1_val          (resp1_val),
        .resp1_rdy          (resp1_rdy),
        .mulreq_msg_a       (mulreq_msg_a),
        .mulreq_msg_b       (mulreq_msg_b),
        .mulreq_val         (mulreq_val),
        .mulreq_rdy         (mulreq_rdy),
        .mulresp_msg_result (mulresp_msg_result),
        .mulresp_val        (mulresp_val),
        .mulresp_rdy        (mulresp_rdy)
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] src0_q[$], src1_q[$];   // {a, b} waiting at each source
    logic [63:0] exp0_q[$], exp1_q[$];   // golden results owed to each port
    logic [63:0] mul_q[$];               // products inside the fake multiplier
    logic [63:0] got0[$], got1[$];       // results delivered to each port
    int          issue_log[$];           // port that issued, in order
    int          n_issue;

    bit          tag_q[$];               // model: ports of in-flight multiplies
    bit          m_prio;                 // model: port favoured on a tie

    int dly0, dly1, sdly0, sdly1;
    int max_src_dly = 0, max_snk_dly = 0;
    bit hold0 = 0, hold1 = 0, mul_rand = 0, mul_resp_en = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] golden(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
    endfunction

    task automatic clear_env();
        src0_q.delete(); src1_q.delete(); exp0_q.delete(); exp1_q.delete();
        mul_q.delete(); got0.delete(); got1.delete(); issue_log.delete();
        tag_q.delete();
        m_prio = 1'b0; n_issue = 0;
        dly0 = 0; dly1 = 0; sdly0 = 0; sdly1 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0_val = 1'b0; req1_val = 1'b0;
        resp0_rdy = 1'b1; resp1_rdy = 1'b1; mulreq_rdy = 1'b1;
        mulresp_val = 1'b1; mulresp_msg_result = {$urandom(), $urandom()};
        #1;
        check("rst_resp0_val",   64'(resp0_val),   64'(0));
        check("rst_resp1_val",   64'(resp1_val),   64'(0));
        check("rst_mulresp_rdy", 64'(mulresp_rdy), 64'(0));
        check("rst_mulreq_val",  64'(mulreq_val),  64'(0));
        check("rst_req0_rdy",    64'(req0_rdy),    64'(1));
        check("rst_req1_rdy",    64'(req1_rdy),    64'(1));
        @(posedge clk);
        #1;
        mulresp_val = 1'b0;
        clear_env();
    endtask

    task automatic cycle();
        bit g, full, empty, anyv, head;
        bit e_mval, e_rdy0, e_rdy1, e_r0v, e_r1v, e_mrdy;
        logic [31:0] e_a, e_b;
        @(negedge clk);
        reset = 1'b0;
        req0_val = (src0_q.size() > 0) && (dly0 == 0);
        {req0_msg_a, req0_msg_b} = (src0_q.size() > 0) ? src0_q[0] : {$urandom(), $urandom()};
        req1_val = (src1_q.size() > 0) && (dly1 == 0);
        {req1_msg_a, req1_msg_b} = (src1_q.size() > 0) ? src1_q[0] : {$urandom(), $urandom()};
        resp0_rdy = !hold0 && (sdly0 == 0);
        resp1_rdy = !hold1 && (sdly1 == 0);
        mulreq_rdy = mul_rand ? ($urandom_range(3, 0) != 0) : 1'b1;
        mulresp_val = (mul_q.size() > 0) && mul_resp_en &&
                      (mul_rand ? ($urandom_range(3, 0) != 0) : 1'b1);
        mulresp_msg_result = (mul_q.size() > 0) ? mul_q[0] : {$urandom(), $urandom()};
        #1;

        full  = (tag_q.size() == DEPTH);
        empty = (tag_q.size() == 0);
        head  = empty ? 1'b0 : tag_q[0];
        anyv  = req0_val || req1_val;
        g     = (req0_val && req1_val) ? m_prio : req1_val;
        e_mval = anyv && !full;
        if (!anyv) begin
            e_rdy0 = mulreq_rdy && !full;
            e_rdy1 = e_rdy0;
        end else begin
            e_rdy0 = (g == 1'b0) && mulreq_rdy && !full;
            e_rdy1 = (g == 1'b1) && mulreq_rdy && !full;
        end
        e_a    = g ? req1_msg_a : req0_msg_a;
        e_b    = g ? req1_msg_b : req0_msg_b;
        e_r0v  = mulresp_val && !empty && (head == 1'b0);
        e_r1v  = mulresp_val && !empty && (head == 1'b1);
        e_mrdy = !empty && (head ? resp1_rdy : resp0_rdy);

        check("mulreq_val",   64'(mulreq_val),   64'(e_mval));
        check("req0_rdy",     64'(req0_rdy),     64'(e_rdy0));
        check("req1_rdy",     64'(req1_rdy),     64'(e_rdy1));
        check("mulreq_msg_a", 64'(mulreq_msg_a), 64'(e_a));
        check("mulreq_msg_b", 64'(mulreq_msg_b), 64'(e_b));
        check("resp0_val",    64'(resp0_val),    64'(e_r0v));
        check("resp1_val",    64'(resp1_val),    64'(e_r1v));
        check("mulresp_rdy",  64'(mulresp_rdy),  64'(e_mrdy));
        check("resp0_msg",    resp0_msg_result,  mulresp_msg_result);
        check("resp1_msg",    resp1_msg_result,  mulresp_msg_result);

        // Environment reacts to what the DUT actually did.
        if (req0_val && req0_rdy) begin
            exp0_q.push_back(golden(req0_msg_a, req0_msg_b));
            void'(src0_q.pop_front());
            issue_log.push_back(0);
            dly0 = int'($urandom_range(max_src_dly, 0));
        end else if (dly0 > 0) dly0--;
        if (req1_val && req1_rdy) begin
            exp1_q.push_back(golden(req1_msg_a, req1_msg_b));
            void'(src1_q.pop_front());
            issue_log.push_back(1);
            dly1 = int'($urandom_range(max_src_dly, 0));
        end else if (dly1 > 0) dly1--;
        if (mulreq_val && mulreq_rdy) begin
            mul_q.push_back(golden(mulreq_msg_a, mulreq_msg_b));
            n_issue++;
        end
        if (mulresp_val && mulresp_rdy) void'(mul_q.pop_front());
        if (resp0_val && resp0_rdy) begin
            got0.push_back(resp0_msg_result);
            if (exp0_q.size() == 0) check("resp0_unexpected", 64'(1), 64'(0));
            else begin
                check("resp0_result", resp0_msg_result, exp0_q[0]);
                void'(exp0_q.pop_front());
            end
            sdly0 = int'($urandom_range(max_snk_dly, 0));
        end else if (sdly0 > 0) sdly0--;
        if (resp1_val && resp1_rdy) begin
            got1.push_back(resp1_msg_result);
            if (exp1_q.size() == 0) check("resp1_unexpected", 64'(1), 64'(0));
            else begin
                check("resp1_result", resp1_msg_result, exp1_q[0]);
                void'(exp1_q.pop_front());
            end
            sdly1 = int'($urandom_range(max_snk_dly, 0));
        end else if (sdly1 > 0) sdly1--;

        // Model advances on its own predicted handshakes.
        if ((e_r0v && resp0_rdy) || (e_r1v && resp1_rdy)) void'(tag_q.pop_front());
        if (e_mval && mulreq_rdy) begin
            tag_q.push_back(g);
            m_prio = !g;
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((src0_q.size() + src1_q.size() + exp0_q.size() + exp1_q.size()
                + mul_q.size()) != 0 && n < budget) begin
            cycle();
            n++;
        end
        check({name, "_drain_in_budget"}, 64'(n < budget), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_env();

        // Port 0 only, four requests.
        do_reset();
        src0_q.push_back({32'h00000003, 32'h00000008});
        src0_q.push_back({32'hffffffff, 32'hffffffff});
        src0_q.push_back({32'hfffffff8, 32'h00000008});
        src0_q.push_back({32'h0deadbee, 32'h10000000});
        drain("p0only", 200);
        check("p0only_n0", 64'(got0.size()), 64'(4));
        check("p0only_n1", 64'(got1.size()), 64'(0));
        if (got0.size() == 4) begin
            check("p0only_r0", got0[0], 64'h00000000_00000018);
            check("p0only_r1", got0[1], 64'h00000000_00000001);
            check("p0only_r2", got0[2], 64'hffffffff_ffffffc0);
            check("p0only_r3", got0[3], 64'h00deadbe_e0000000);
        end

        // Both ports continuously valid: strict alternation from port 0.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            src0_q.push_back({32'(i), 32'(i)});
            src1_q.push_back({32'(i + 4), 32'(i + 4)});
        end
        drain("alt", 200);
        check("alt_n_issue", 64'(issue_log.size()), 64'(6));
        for (int i = 0; i < 6 && i < issue_log.size(); i++)
            check("alt_order", 64'(issue_log[i]), 64'(i % 2));
        if (got0.size() == 3 && got1.size() == 3) begin
            check("alt_r0_0", got0[0], 64'h1);
            check("alt_r0_1", got0[1], 64'h4);
            check("alt_r0_2", got0[2], 64'h9);
            check("alt_r1_0", got1[0], 64'h19);
            check("alt_r1_1", got1[1], 64'h24);
            check("alt_r1_2", got1[2], 64'h31);
        end else check("alt_counts", 64'(got0.size() + got1.size()), 64'(6));

        // Sink backpressure fills the tag FIFO.
        do_reset();
        hold0 = 1;
        for (int i = 0; i < 4; i++) src0_q.push_back({32'(i + 10), 32'h00000100});
        for (int i = 0; i < 6; i++) cycle();
        check("bp_n_issue", 64'(n_issue), 64'(DEPTH));
        check("bp_req0_rdy", 64'(req0_rdy), 64'(0));
        hold0 = 0;
        drain("bp", 200);
        check("bp_n0", 64'(got0.size()), 64'(4));

        // Head tag on a stalled port 1 blocks port 0 results.
        do_reset();
        hold1 = 1;
        src1_q.push_back({32'h00000007, 32'hfffffffd});
        cycle();
        for (int i = 0; i < 3; i++) src0_q.push_back({32'(i + 2), 32'h00000003});
        for (int i = 0; i < 10; i++) cycle();
        check("stall_n0", 64'(got0.size()), 64'(0));
        check("stall_n1", 64'(got1.size()), 64'(0));
        hold1 = 0;
        drain("stall", 200);
        check("stall_n0_end", 64'(got0.size()), 64'(3));
        check("stall_n1_end", 64'(got1.size()), 64'(1));

        // Reset with two tags in flight, priority left at port 1.
        do_reset();
        mul_resp_en = 0;
        src0_q.push_back({32'h00000011, 32'h00000002});
        src0_q.push_back({32'h00000013, 32'h00000002});
        for (int i = 0; i < 3; i++) cycle();
        check("rmid_n_issue", 64'(n_issue), 64'(2));
        do_reset();
        mul_resp_en = 1;
        src0_q.push_back({32'h00000021, 32'h00000003});
        src1_q.push_back({32'h00000031, 32'h00000003});
        cycle();
        check("rmid_resp0_val", 64'(resp0_val), 64'(0));
        check("rmid_resp1_val", 64'(resp1_val), 64'(0));
        check("rmid_first_port", 64'(issue_log.size() > 0 ? issue_log[0] : 9), 64'(0));
        drain("rmid", 200);
        check("rmid_n0", 64'(got0.size()), 64'(1));
        check("rmid_n1", 64'(got1.size()), 64'(1));

        // Randomized delays everywhere.
        do_reset();
        max_src_dly = 3; max_snk_dly = 3; mul_rand = 1;
        for (int i = 0; i < 50; i++) begin
            src0_q.push_back({$urandom(), $urandom()});
            src1_q.push_back({$urandom(), $urandom()});
        end
        drain("rand", 4000);
        check("rand_n0", 64'(got0.size()), 64'(50));
        check("rand_n1", 64'(got1.size()), 64'(50));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
